// File: rtl/jtkiwi_col_draw.sv
// rtl/jtkiwi_col_draw.sv - tile row draw engine: two ROM fetches, 4bpp decode, line buffer writes
// One request draws 16 pixels; the half shown first on screen is fetched first.
module jtkiwi_col_draw #(
    parameter int PALW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              draw,
    output logic              busy,
    input  logic [15:0]       code,
    input  logic [15:0]       attr,
    input  logic [8:0]        xpos,
    input  logic [3:0]        ysub,
    input  logic              flip,
    output logic [17:0]       rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    output logic [8:0]        buf_addr,
    output logic              buf_we,
    output logic [PALW+3:0]   buf_din
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

    state_t            state_q;
    logic [12:0]       tile_q;
    logic [PALW-1:0]   pal_q;
    logic [8:0]        xpos_q;
    logic [3:0]        row_q;
    logic              hf_q;
    logic              flip_q;
    logic              half_q;
    logic              seg_q;
    logic              settle_q;
    logic [31:0]       data_q;
    logic [3:0]        cnt_q;

    logic              hf_d;
    logic              vf_d;
    logic [3:0]        row_d;
    logic [2:0]        n_d;
    logic [2:0]        k_d;
    logic [31:0]       src_d;
    logic [3:0]        pix_d;
    logic [8:0]        sum_d;
    logic [8:0]        addr_d;
    logic              emit_d;

    logic              unused_bits;
    assign unused_bits = &{1'b0, code[13], attr[15-PALW:0]};

    // Pixel 0 of a half is decoded straight from rom_data in the latch cycle,
    // the remaining seven from the held word.
    always_comb begin
        hf_d   = code[15] ^ flip;
        vf_d   = code[14] ^ flip;
        row_d  = ysub ^ {4{vf_d}};
        n_d    = (state_q == FETCH) ? 3'd0 : cnt_q[2:0];
        src_d  = (state_q == FETCH) ? rom_data : data_q;
        k_d    = hf_q ? ~n_d : n_d;
        pix_d  = {src_d[5'd31 - {2'b00, k_d}], src_d[5'd23 - {2'b00, k_d}],
                  src_d[5'd15 - {2'b00, k_d}], src_d[5'd7  - {2'b00, k_d}]};
        sum_d  = xpos_q + {5'd0, seg_q, n_d};
        addr_d = flip_q ? ~sum_d : sum_d;
        emit_d = ((state_q == FETCH) && !settle_q && rom_ok) ||
                 ((state_q == DRAW) && (cnt_q != 4'd8));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
            tile_q   <= '0;
            pal_q    <= '0;
            xpos_q   <= '0;
            row_q    <= '0;
            hf_q     <= 1'b0;
            flip_q   <= 1'b0;
            half_q   <= 1'b0;
            seg_q    <= 1'b0;
            settle_q <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (draw) begin
                        tile_q   <= code[12:0];
                        pal_q    <= attr[15 -: PALW];
                        xpos_q   <= xpos;
                        row_q    <= row_d;
                        hf_q     <= hf_d;
                        flip_q   <= flip;
                        half_q   <= hf_d;
                        seg_q    <= 1'b0;
                        settle_q <= 1'b1;
                        rom_addr <= {code[12:0], hf_d, row_d};
                        rom_cs   <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (rom_ok) begin
                        data_q  <= rom_data;
                        rom_cs  <= 1'b0;
                        cnt_q   <= 4'd1;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (cnt_q == 4'd8) begin
                        if (!seg_q) begin
                            seg_q    <= 1'b1;
                            half_q   <= ~half_q;
                            rom_addr <= {tile_q, ~half_q, row_q};
                            rom_cs   <= 1'b1;
                            settle_q <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Address and colour only move on real writes; transparent slots hold them.
            if (emit_d) begin
                buf_we <= |pix_d;
                if (|pix_d) begin
                    buf_addr <= addr_d;
                    buf_din  <= {pal_q, pix_d};
                end
            end else begin
                buf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtkiwi_col_draw.sv
// tb/tb_jtkiwi_col_draw.sv - bench for jtkiwi_col_draw
module tb_jtkiwi_col_draw;

    logic        clk = 1'b0;
    logic        rst;
    logic        draw;
    logic        busy;
    logic [15:0] code;
    logic [15:0] attr;
    logic [8:0]  xpos;
    logic [3:0]  ysub;
    logic        flip;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic        buf_we;
    logic [8:0]  buf_din;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] rom_mem [logic [17:0]];

    int          obs_we_cnt;
    int          obs_busy_cnt;
    logic [8:0]  obs_first_addr;
    logic [8:0]  obs_last_addr;
    logic [8:0]  obs_last_din;
    logic [17:0] obs_addr_a;
    logic [17:0] obs_addr_b;

    jtkiwi_col_draw #(.PALW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .draw     (draw),
        .busy     (busy),
        .code     (code),
        .attr     (attr),
        .xpos     (xpos),
        .ysub     (ysub),
        .flip     (flip),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .buf_addr (buf_addr),
        .buf_we   (buf_we),
        .buf_din  (buf_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        logic [31:0] h;
        if (rom_mem.exists(a)) return rom_mem[a];
        h = {14'd0, a} * 32'h9E3779B1;
        return h ^ (h >> 13);
    endfunction

    task automatic rand_inputs();
        code = 16'($urandom);
        attr = 16'($urandom);
        xpos = 9'($urandom);
        ysub = 4'($urandom);
        flip = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            draw = 1'b0;
            rand_inputs();
            rom_ok   = 1'($urandom);
            rom_data = $urandom;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_cs", rom_cs, 0);
            chk("idle_we", buf_we, 0);
        end
    endtask

    // Expected timeline: fetch A (settle + s0 stalls + latch), 8 pixel slots,
    // fetch B (settle + s1 stalls + latch), 8 pixel slots, then idle.
    task automatic run_req(input logic [15:0] c, input logic [15:0] a, input logic [8:0] x,
                           input logic [3:0] y, input logic f, input int s0, input int s1,
                           input bit glitch, input int abort_at);
        bit          e_busy [64];
        bit          e_cs   [64];
        bit          e_we   [64];
        bit          ok_plan[64];
        logic [17:0] e_ra   [64];
        logic [8:0]  e_ba   [64];
        logic [8:0]  e_din  [64];
        int          n_end, hf, vf, row, tile, j, k, t, fb;
        logic [31:0] w;
        logic [3:0]  pix;
        logic [8:0]  sx;

        n_end = 21 + s0 + s1;
        hf    = c[15] ^ f;
        vf    = c[14] ^ f;
        row   = vf ? (15 - y) : y;
        tile  = c[12:0];
        for (int i = 0; i < 64; i++) begin
            e_busy[i]  = (i >= 1) && (i < n_end);
            e_cs[i]    = 0;
            e_we[i]    = 0;
            ok_plan[i] = 1'($urandom);
            e_ra[i]    = '0;
            e_ba[i]    = '0;
            e_din[i]   = '0;
        end
        for (int i = 1; i <= 2 + s0; i++) begin
            e_cs[i] = 1;
            e_ra[i] = 18'(tile * 32 + hf * 16 + row);
            if (i > 1) ok_plan[i] = (i == 2 + s0);
        end
        fb = 10 + s0;
        for (int i = fb + 1; i <= fb + 2 + s1; i++) begin
            e_cs[i] = 1;
            e_ra[i] = 18'(tile * 32 + (1 - hf) * 16 + row);
            if (i > fb + 1) ok_plan[i] = (i == fb + 2 + s1);
        end
        for (int s = 0; s < 16; s++) begin
            j   = hf ? 15 - s : s;
            w   = rom_word(18'(tile * 32 + (j / 8) * 16 + row));
            k   = j % 8;
            pix = {w[31 - k], w[23 - k], w[15 - k], w[7 - k]};
            t   = (s < 8) ? 3 + s0 + s : 13 + s0 + s1 + (s - 8);
            sx  = x + 9'(s);
            e_we[t]  = (pix != 0);
            e_ba[t]  = f ? ~sx : sx;
            e_din[t] = {a[15:11], pix};
        end

        obs_we_cnt = 0;
        obs_busy_cnt = 0;
        obs_first_addr = 'x;
        obs_last_addr = 'x;
        obs_last_din = 'x;
        obs_addr_a = 'x;
        obs_addr_b = 'x;

        for (int i = 0; i < n_end; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                draw = 1'b1;
                code = c; attr = a; xpos = x; ysub = y; flip = f;
            end else begin
                rand_inputs();
                draw = glitch && ($urandom_range(0, 2) == 0);
            end
            rom_ok   = ok_plan[i];
            rom_data = rom_word(rom_addr);
            if (i == abort_at) rst = 1'b1;
            @(negedge clk);
            if (i == abort_at) begin
                chk("abort_busy", busy, 0);
                chk("abort_we", buf_we, 0);
                chk("abort_cs", rom_cs, 0);
                return;
            end
            chk("busy", busy, e_busy[i]);
            chk("rom_cs", rom_cs, e_cs[i]);
            if (e_cs[i]) chk("rom_addr", rom_addr, e_ra[i]);
            chk("buf_we", buf_we, e_we[i]);
            if (e_we[i]) begin
                chk("buf_addr", buf_addr, e_ba[i]);
                chk("buf_din", buf_din, e_din[i]);
            end
            if (busy) obs_busy_cnt++;
            if (buf_we) begin
                obs_we_cnt++;
                if (obs_we_cnt == 1) obs_first_addr = buf_addr;
                obs_last_addr = buf_addr;
                obs_last_din  = buf_din;
            end
            if (i == 1) obs_addr_a = rom_addr;
            if (i == fb + 1) obs_addr_b = rom_addr;
        end
    endtask

    initial begin
        int s0, s1, gap;
        logic [15:0] c;

        rst = 1'b1; draw = 1'b0; rom_ok = 1'b0; rom_data = '0;
        code = '0; attr = '0; xpos = '0; ysub = '0; flip = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_we", buf_we, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_buf_din", buf_din, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        // Basic row, followed back-to-back by the hflip row.
        rom_mem[18'h000A3] = 32'hFFFFFFFF;
        rom_mem[18'h000B3] = 32'h00000000;
        run_req(16'h0005, 16'hF800, 9'h010, 4'd3, 1'b0, 0, 0, 1'b0, -1);
        chk("basic_addr_a", obs_addr_a, 18'h000A3);
        chk("basic_addr_b", obs_addr_b, 18'h000B3);
        chk("basic_writes", obs_we_cnt, 8);
        chk("basic_first_x", obs_first_addr, 9'h010);
        chk("basic_last_x", obs_last_addr, 9'h017);
        chk("basic_din", obs_last_din, 9'h1FF);
        chk("basic_busy_len", obs_busy_cnt, 20);

        rom_mem[18'h000A3] = 32'h80808080;
        run_req(16'h8005, 16'hF800, 9'h010, 4'd3, 1'b0, 0, 0, 1'b0, -1);
        chk("hflip_addr_a", obs_addr_a, 18'h000B3);
        chk("hflip_writes", obs_we_cnt, 1);
        chk("hflip_x", obs_first_addr, 9'h01F);
        chk("hflip_din", obs_last_din, 9'h1FF);
        idle(2);

        // Global flip with x wrap: row inverted, half 1 first, addresses complemented.
        rom_mem[18'h000AC] = 32'hFFFFFFFF;
        rom_mem[18'h000BC] = 32'hFFFFFFFF;
        run_req(16'h0005, 16'h0800, 9'h1FC, 4'd3, 1'b1, 0, 0, 1'b0, -1);
        chk("wrap_addr_a", obs_addr_a, 18'h000BC);
        chk("wrap_writes", obs_we_cnt, 16);
        chk("wrap_first_x", obs_first_addr, 9'h003);
        chk("wrap_last_x", obs_last_addr, 9'h1F4);
        idle(2);

        // Ten-cycle stall in the first fetch with stray draw pulses.
        run_req(16'h0123, 16'h5000, 9'h080, 4'd7, 1'b0, 10, 0, 1'b1, -1);
        chk("stall_busy_len", obs_busy_cnt, 30);
        idle(1);

        for (int r = 0; r < 40; r++) begin
            c = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rom_mem[{c[12:0], 5'd0} | 18'($urandom_range(0, 31))] = $urandom & $urandom;
            end
            s0  = $urandom_range(0, 4);
            s1  = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            run_req(c, 16'($urandom), 9'($urandom), 4'($urandom), 1'($urandom),
                    s0, s1, 1'($urandom), -1);
            if (gap != 0) idle(gap);
        end

        // Reset while pixel 4 of the first half is on the bus.
        rom_mem[18'h000A3] = 32'hFFFFFFFF;
        run_req(16'h0005, 16'hF800, 9'h010, 4'd3, 1'b0, 0, 0, 1'b0, 7);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("inrst_busy", busy, 0);
            chk("inrst_rom_addr", rom_addr, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
